core_main: RTL and testbench

CORE_MAIN -- requirements
Module: core_main

---
 rtl/core_main.sv | 224 ++++++++++++++++++++++
 tb/tb_core_main.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_main.sv
// Single-cycle RV32I core: external instruction fetch, internal register file and data memory.
// Optional feature macro CORE_MAIN_ILLEGAL_TRAP_EN: illegal instructions set a sticky flag and halt the core.
module core_main #(
    parameter int unsigned DMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        enable,
    output logic [31:0] pc,
    output logic [31:0] res_out,
    output logic        illegal
);
    localparam int unsigned AW = $clog2(DMEM_DEPTH);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7], instruction[30:25],
                    instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'b0};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12], instruction[20],
                    instruction[30:21], 1'b0};

    logic [31:0] regs [32];
    logic [31:0] dmem [DMEM_DEPTH];
    logic [31:0] rs1_val, rs2_val;

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

    // Decode legality of opcode/funct3/funct7 combinations
    logic legal;
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: legal = 1'b1;
            OP_JALR:   legal = (funct3 == 3'b000);
            OP_BRANCH: legal = (funct3[2:1] != 2'b01);
            OP_LOAD:   legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                               (funct3 == 3'b100) || (funct3 == 3'b101);
            OP_STORE:  legal = !funct3[2] && (funct3[1:0] != 2'b11);
            OP_IMM: begin
                case (funct3)
                    3'b001:  legal = (funct7 == 7'b0000000);
                    3'b101:  legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    default: legal = 1'b1;
                endcase
            end
            OP_REG:    legal = (funct7 == 7'b0000000) ||
                               ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            OP_FENCE:  legal = (funct3 == 3'b000);
            OP_SYSTEM: legal = (instruction[19:7] == 13'd0) && (instruction[31:21] == 11'd0);
            default:   legal = 1'b0;
        endcase
    end

    // ALU shared by register and immediate forms
    logic [31:0] alu_b, alu;
    logic [4:0]  shamt;
    always_comb begin
        alu_b = (opcode == OP_REG) ? rs2_val : imm_i;
        shamt = alu_b[4:0];
        case (funct3)
            3'b000:  alu = ((opcode == OP_REG) && funct7[5]) ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001:  alu = rs1_val << shamt;
            3'b010:  alu = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'b011:  alu = {31'd0, rs1_val < alu_b};
            3'b100:  alu = rs1_val ^ alu_b;
            3'b101:  alu = funct7[5] ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
            3'b110:  alu = rs1_val | alu_b;
            default: alu = rs1_val & alu_b;
        endcase
    end

    logic taken;
    always_comb begin
        case (funct3)
            3'b000:  taken = (rs1_val == rs2_val);
            3'b001:  taken = (rs1_val != rs2_val);
            3'b100:  taken = $signed(rs1_val) < $signed(rs2_val);
            3'b101:  taken = $signed(rs1_val) >= $signed(rs2_val);
            3'b110:  taken = rs1_val < rs2_val;
            3'b111:  taken = rs1_val >= rs2_val;
            default: taken = 1'b0;
        endcase
    end

    // Data memory addressing, load extraction and store lane selection
    logic [31:0]   addr, word, ld_val, st_data;
    logic [AW-1:0] mem_idx;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [3:0]    st_be;

    assign addr    = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign mem_idx = addr[AW+1:2];
    assign word    = dmem[mem_idx];

    always_comb begin
        ld_byte = word[{addr[1:0], 3'b000} +: 8];
        ld_half = addr[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_val = {24'd0, ld_byte};
            3'b101:  ld_val = {16'd0, ld_half};
            default: ld_val = word;
        endcase
    end

    always_comb begin
        st_be   = 4'b1111;
        st_data = rs2_val;
        case (funct3[1:0])
            2'b00: begin
                st_be   = 4'b0001 << addr[1:0];
                st_data = {4{rs2_val[7:0]}};
            end
            2'b01: begin
                st_be   = addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{rs2_val[15:0]}};
            end
            default: ;
        endcase
    end

    // Writeback value, write enables and next pc
    logic [31:0] result, next_pc, pc_plus4;
    logic        rd_we, mem_we;
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        result  = 32'd0;
        rd_we   = 1'b0;
        mem_we  = 1'b0;
        next_pc = pc_plus4;
        if (legal) begin
            case (opcode)
                OP_LUI:   begin result = imm_u;      rd_we = 1'b1; end
                OP_AUIPC: begin result = pc + imm_u; rd_we = 1'b1; end
                OP_JAL: begin
                    result  = pc_plus4;
                    rd_we   = 1'b1;
                    next_pc = pc + imm_j;
                end
                OP_JALR: begin
                    result  = pc_plus4;
                    rd_we   = 1'b1;
                    next_pc = (rs1_val + imm_i) & 32'hFFFF_FFFE;
                end
                OP_BRANCH: begin
                    result = {31'd0, taken};
                    if (taken) next_pc = pc + imm_b;
                end
                OP_LOAD:  begin result = ld_val; rd_we = 1'b1; end
                OP_STORE: begin result = addr;   mem_we = 1'b1; end
                OP_IMM, OP_REG: begin result = alu; rd_we = 1'b1; end
                default: ;
            endcase
        end
    end

    assign res_out = result;

    logic retire;
`ifdef CORE_MAIN_ILLEGAL_TRAP_EN
    assign retire = enable && !illegal && legal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                              illegal <= 1'b0;
        else if (enable && !illegal && !legal) illegal <= 1'b1;
    end
`else
    assign retire  = enable;
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        pc <= 32'd0;
        else if (retire) pc <= next_pc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (retire && rd_we && (rd != 5'd0)) begin
            regs[rd] <= result;
        end
    end

    // Memory contents survive reset; reset only blocks the write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
        end else if (retire && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) dmem[mem_idx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_core_main.sv
// Randomized bench for core_main checked against an instruction-level model of RV32I semantics.
module tb_core_main;
    localparam int unsigned DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst, enable, illegal;
    logic [31:0] instruction, pc, res_out;

    core_main #(.DMEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .enable(enable),
        .pc(pc), .res_out(res_out), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef enum int {
        I_LUI, I_AUIPC, I_JAL, I_JALR, I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU,
        I_LB, I_LH, I_LW, I_LBU, I_LHU, I_SB, I_SH, I_SW,
        I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI, I_SLLI, I_SRLI, I_SRAI,
        I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU, I_XOR, I_OR, I_AND, I_SRL, I_SRA,
        I_FENCE, I_ECALL, I_EBREAK
    } op_e;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_mem  [DEPTH];
    logic [31:0] m_pc;
    logic        m_halt;

    logic        chk_on = 1'b0, exp_res_chk = 1'b0, exp_ill = 1'b0;
    logic [31:0] exp_res = 32'd0, exp_pc = 32'd0;

    logic [31:0] p_res, p_npc, p_mval;
    logic        p_ok, p_wrd, p_wm, p_en;
    int          p_midx, p_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] encode(input op_e op, input int rd_i, input int rs1_i,
                                           input int rs2_i, input logic [31:0] imm);
        logic [31:0] w;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        rd = 5'(rd_i); rs1 = 5'(rs1_i); rs2 = 5'(rs2_i);
        w = 32'd0; f3 = 3'd0;
        f7 = (op == I_SUB || op == I_SRA || op == I_SRAI) ? 7'h20 : 7'h00;
        case (op)
            I_BNE, I_LH, I_SH, I_SLLI, I_SLL:                  f3 = 3'd1;
            I_LW, I_SW, I_SLTI, I_SLT:                         f3 = 3'd2;
            I_SLTIU, I_SLTU:                                   f3 = 3'd3;
            I_BLT, I_LBU, I_XORI, I_XOR:                       f3 = 3'd4;
            I_BGE, I_LHU, I_SRLI, I_SRAI, I_SRL, I_SRA:        f3 = 3'd5;
            I_BLTU, I_ORI, I_OR:                               f3 = 3'd6;
            I_BGEU, I_ANDI, I_AND:                             f3 = 3'd7;
            default:                                           f3 = 3'd0;
        endcase
        case (op)
            I_LUI:   w = {imm[31:12], rd, 7'h37};
            I_AUIPC: w = {imm[31:12], rd, 7'h17};
            I_JAL:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
            I_JALR:  w = {imm[11:0], rs1, f3, rd, 7'h67};
            I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU:
                     w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
            I_LB, I_LH, I_LW, I_LBU, I_LHU:
                     w = {imm[11:0], rs1, f3, rd, 7'h03};
            I_SB, I_SH, I_SW:
                     w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
            I_SLLI, I_SRLI, I_SRAI:
                     w = {f7, imm[4:0], rs1, f3, rd, 7'h13};
            I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI:
                     w = {imm[11:0], rs1, f3, rd, 7'h13};
            I_FENCE:  w = 32'h0FF0000F;
            I_ECALL:  w = 32'h00000073;
            I_EBREAK: w = 32'h00100073;
            default: w = {f7, rs2, rs1, f3, rd, 7'h33};
        endcase
        return w;
    endfunction

    // Architectural effect of one instruction on the model state
    task automatic model_eval(input op_e op, input int rs1, input int rs2, input logic [31:0] imm,
                              output logic [31:0] res, output logic res_ok, output logic [31:0] npc,
                              output logic wr_rd, output logic wr_mem, output int midx,
                              output logic [31:0] mval);
        logic [31:0] a, b, addr, w, mask;
        logic [7:0]  bt;
        logic [15:0] hw;
        int k, h, sh;
        a = m_regs[rs1]; b = m_regs[rs2];
        res = 32'd0; res_ok = 1'b1; npc = m_pc + 32'd4; wr_rd = 1'b1; wr_mem = 1'b0;
        addr = a + imm;
        midx = int'((addr >> 2) % DEPTH);
        k = int'(addr % 4);
        h = int'(addr[1]);
        w = m_mem[midx]; mval = w;
        bt = 8'(w >> (8 * k));
        hw = 16'(w >> (16 * h));
        sh = (op == I_SLLI || op == I_SRLI || op == I_SRAI) ? int'(imm % 32) : int'(b % 32);
        case (op)
            I_LUI:   res = imm;
            I_AUIPC: res = m_pc + imm;
            I_JAL:   begin res = m_pc + 32'd4; npc = m_pc + imm; end
            I_JALR:  begin res = m_pc + 32'd4; npc = (a + imm) & 32'hFFFF_FFFE; end
            I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU: begin
                wr_rd = 1'b0;
                case (op)
                    I_BEQ:   res = 32'(a == b);
                    I_BNE:   res = 32'(a != b);
                    I_BLT:   res = 32'($signed(a) < $signed(b));
                    I_BGE:   res = 32'($signed(a) >= $signed(b));
                    I_BLTU:  res = 32'(a < b);
                    default: res = 32'(a >= b);
                endcase
                if (res == 32'd1) npc = m_pc + imm;
            end
            I_LB:  res = {{24{bt[7]}}, bt};
            I_LH:  res = {{16{hw[15]}}, hw};
            I_LW:  res = w;
            I_LBU: res = {24'd0, bt};
            I_LHU: res = {16'd0, hw};
            I_SB, I_SH, I_SW: begin
                wr_rd = 1'b0; wr_mem = 1'b1; res = addr;
                if (op == I_SB) begin
                    mask = 32'hFF << (8 * k);
                    mval = (w & ~mask) | ((b & 32'hFF) << (8 * k));
                end else if (op == I_SH) begin
                    mask = 32'hFFFF << (16 * h);
                    mval = (w & ~mask) | ((b & 32'hFFFF) << (16 * h));
                end else begin
                    mval = b;
                end
            end
            I_ADDI:  res = a + imm;
            I_SLTI:  res = 32'($signed(a) < $signed(imm));
            I_SLTIU: res = 32'(a < imm);
            I_XORI:  res = a ^ imm;
            I_ORI:   res = a | imm;
            I_ANDI:  res = a & imm;
            I_SLLI, I_SLL: res = a << sh;
            I_SRLI, I_SRL: res = a >> sh;
            I_SRAI, I_SRA: res = 32'($signed(a) >>> sh);
            I_ADD:   res = a + b;
            I_SUB:   res = a - b;
            I_SLT:   res = 32'($signed(a) < $signed(b));
            I_SLTU:  res = 32'(a < b);
            I_XOR:   res = a ^ b;
            I_OR:    res = a | b;
            I_AND:   res = a & b;
            default: begin res_ok = 1'b0; wr_rd = 1'b0; end
        endcase
    endtask

    // Apply an instruction and wait until outputs are settled
    task automatic drive(input op_e op, input int rd, input int rs1, input int rs2,
                         input logic [31:0] imm, input logic en);
        model_eval(op, rs1, rs2, imm, p_res, p_ok, p_npc, p_wrd, p_wm, p_midx, p_mval);
        p_rd = rd; p_en = en;
        instruction = encode(op, rd, rs1, rs2, imm);
        enable = en;
        exp_res = p_res; exp_res_chk = p_ok; exp_pc = m_pc; chk_on = 1'b1;
        @(negedge clk);
    endtask

    task automatic commit();
        @(posedge clk);
        if (p_en && !m_halt) begin
            if (p_wm) m_mem[p_midx] = p_mval;
            if (p_wrd && p_rd != 0) m_regs[p_rd] = p_res;
            m_pc = p_npc;
        end
        #1;
    endtask

    function automatic logic [31:0] rand_imm(input op_e op);
        logic [31:0] r;
        r = $urandom;
        case (op)
            I_LUI, I_AUIPC: return r & 32'hFFFF_F000;
            I_JAL: return {{11{r[20]}}, r[20:1], 1'b0};
            I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU: return {{19{r[12]}}, r[12:1], 1'b0};
            I_SLLI, I_SRLI, I_SRAI: return r & 32'd31;
            default: return {{20{r[11]}}, r[11:0]};
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            chk("pc", pc, exp_pc);
            if (exp_res_chk) chk("res_out", res_out, exp_res);
            chk("illegal", 32'(illegal), 32'(exp_ill));
        end
    end

    initial begin
        logic [31:0] p_save;
        op_e         op;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 32'd0;
        m_pc = 32'd0; m_halt = 1'b0;
        rst = 1'b1; enable = 1'b0; instruction = 32'h00500093;
        #1 rst = 1'b0;
        #1;
        chk("reset_pc", pc, 32'd0);
        chk("reset_illegal", 32'(illegal), 32'd0);
        @(posedge clk); #1 rst = 1'b1;

        // Held for 20 cycles with enable low
        for (int i = 0; i < 20; i++) begin drive(I_ADDI, 1, 0, 0, 32'd5, 1'b0); commit(); end
        chk("hold_pc", pc, 32'd0);
        drive(I_ADD, 2, 1, 1, 32'd0, 1'b0); chk("hold_x1", res_out, 32'd0); commit();

        drive(I_ADDI, 1, 0, 0, 32'd5, 1'b1); chk("addi_res", res_out, 32'd5); commit();
        chk("addi_pc", pc, 32'd4);
        drive(I_ADD, 2, 1, 1, 32'd0, 1'b1); chk("add_res", res_out, 32'd10); commit();
        chk("add_pc", pc, 32'd8);
        drive(I_SW, 0, 0, 2, 32'd8, 1'b1); commit();
        drive(I_LW, 3, 0, 0, 32'd8, 1'b1); chk("lw_res", res_out, 32'd10); commit();
        drive(I_ADD, 4, 3, 0, 32'd0, 1'b1); chk("x3_val", res_out, 32'd10); commit();
        drive(I_BEQ, 0, 0, 0, 32'd8, 1'b1); commit(); chk("beq_pc", pc, 32'd28);
        drive(I_BNE, 0, 0, 0, 32'd8, 1'b1); commit(); chk("bne_pc", pc, 32'd32);
        drive(I_LUI, 5, 0, 0, 32'h12345000, 1'b1); chk("lui_res", res_out, 32'h12345000); commit();
        drive(I_ADDI, 0, 0, 0, 32'd7, 1'b1); commit();
        drive(I_ADD, 6, 0, 0, 32'd0, 1'b1); chk("x0_zero", res_out, 32'd0); commit();

        // Fill every memory word with a known value
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive(I_ADDI, 9, 0, 0, rand_imm(I_ADDI), 1'b1); commit();
            drive(I_SW, 0, 0, 9, 32'(4 * i), 1'b1); commit();
        end

        for (int n = 0; n < 3000; n++) begin
            op = op_e'($urandom_range(0, int'(I_EBREAK)));
            drive(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), rand_imm(op), ($urandom_range(0, 9) != 0));
            commit();
        end

        // Reset in the middle of a store abandons it
        drive(I_ADDI, 9, 0, 0, 32'h5A5, 1'b1); commit();
        drive(I_SW, 0, 0, 0, 32'd12, 1'b1); commit();
        drive(I_SW, 0, 0, 9, 32'd12, 1'b1);
        #2 rst = 1'b0;
        #1 chk("rst_async_pc", pc, 32'd0);
        @(posedge clk); #1;
        chk("rst_hold_pc", pc, 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pc = 32'd0;
        drive(I_ADD, 10, 9, 0, 32'd0, 1'b1); chk("rst_regs", res_out, 32'd0); commit();
        drive(I_LW, 11, 0, 0, 32'd12, 1'b1); chk("abort_sw", res_out, 32'd0); commit();

        // All-zero word is not a valid instruction
        p_save = m_pc;
        instruction = 32'h00000000; enable = 1'b1;
        exp_res_chk = 1'b0; exp_pc = m_pc;
        @(negedge clk); @(posedge clk); #1;
`ifdef CORE_MAIN_ILLEGAL_TRAP_EN
        m_halt = 1'b1; exp_ill = 1'b1;
        chk("trap_pc", pc, p_save);
        chk("trap_flag", 32'(illegal), 32'd1);
        drive(I_ADDI, 1, 0, 0, 32'd3, 1'b1); commit();
        chk("halt_pc", pc, p_save);
`else
        m_pc = p_save + 32'd4;
        chk("nop_pc", pc, p_save + 32'd4);
        chk("nop_flag", 32'(illegal), 32'd0);
        drive(I_ADDI, 1, 0, 0, 32'd3, 1'b1); commit();
        chk("after_nop_pc", pc, p_save + 32'd8);
`endif
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
